// File: rtl/serial_sub.sv
// ----------------------------------------------------------------------------
// serial_sub -- bit-serial unsigned subtractor
//
// Computes (a - b) mod 2^WIDTH one bit per clock, LSB first. It uses a single
// full-subtractor cell (fsub) and registers the cell's borrow-out so that it
// becomes the borrow-in of the next bit. Operands are accepted through a
// start/done handshake.
//
// Ports (serial_sub):
//   clk     in   1      clock, all state changes on the rising edge
//   rst_n   in   1      synchronous active-low reset
//   start   in   1      request, only looked at while idle
//   a       in   WIDTH  minuend, captured on the accepting edge
//   b       in   WIDTH  subtrahend, captured on the accepting edge
//   busy    out  1      high while a subtraction is in progress
//   done    out  1      one-cycle completion pulse
//   diff    out  WIDTH  (a - b) mod 2^WIDTH, held until the next completion
//   borrow  out  1      final borrow-out (a < b), held together with diff
//
// Ports (fsub):
//   a, b, bin  in   1  minuend bit, subtrahend bit, borrow-in
//   d, bout    out 1  difference bit, borrow-out
// ----------------------------------------------------------------------------

module fsub (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    // A borrow leaves this bit when 0-1 happens, or when the bits are equal
    // and a borrow came in from below.
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_sd;
    logic             r_br;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic             r_done;

    logic             w_d;
    logic             w_bout;
    logic             w_unused_sd_lsb;

    fsub u_fsub (
        .a    (r_sa[0]),
        .b    (r_sb[0]),
        .bin  (r_br),
        .d    (w_d),
        .bout (w_bout)
    );

    // The LSB of the result shift register always falls off the end on the
    // final shift, so it never reaches diff.
    assign w_unused_sd_lsb = r_sd[0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_sa     <= '0;
            r_sb     <= '0;
            r_sd     <= '0;
            r_br     <= 1'b0;
            r_cnt    <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_sa    <= a;
                        r_sb    <= b;
                        r_sd    <= '0;
                        r_br    <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_sd  <= {w_d, r_sd[WIDTH-1:1]};
                    r_sa  <= {1'b0, r_sa[WIDTH-1:1]};
                    r_sb  <= {1'b0, r_sb[WIDTH-1:1]};
                    r_br  <= w_bout;
                    r_cnt <= r_cnt + 1'b1;
                    // The MSB is being resolved right now, so the finished
                    // result is the current bit on top of the shifted partial.
                    if (r_cnt == LAST_CNT) begin
                        r_diff   <= {w_d, r_sd[WIDTH-1:1]};
                        r_borrow <= w_bout;
                        r_done   <= 1'b1;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy   = (r_state == RUN);
    assign done   = r_done;
    assign diff   = r_diff;
    assign borrow = r_borrow;

endmodule

// File: tb/tb_serial_sub.sv
// ----------------------------------------------------------------------------
// tb_serial_sub -- self-checking bench for serial_sub.
// Drives an 8-bit instance with directed vectors and a 3-bit instance with
// every operand pair issued back-to-back. A transaction-level model of each
// instance predicts busy/done/diff/borrow every cycle.
// ----------------------------------------------------------------------------

module tb_serial_sub;

    logic clk = 1'b0;
    logic rst_n;

    logic       start8, busy8, done8, borrow8;
    logic [7:0] a8, b8, diff8;
    logic       start3, busy3, done3, borrow3;
    logic [2:0] a3, b3, diff3;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;
    logic cmpEn  = 1'b0;

    always #5 clk = ~clk;

    serial_sub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8)
    );

    serial_sub #(.WIDTH(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3),
        .busy(busy3), .done(done3), .diff(diff3), .borrow(borrow3)
    );

    always @(posedge clk) cycle <= cycle + 1;

    // Transaction-level model: an accepted request finishes WIDTH edges later
    // with the arithmetic difference; requests while busy are dropped.
    logic       m8Busy, m8Done, m8Borrow, m8PendBorrow;
    logic [7:0] m8Diff, m8PendDiff;
    int         m8Left;
    logic       m3Busy, m3Done, m3Borrow, m3PendBorrow;
    logic [2:0] m3Diff, m3PendDiff;
    int         m3Left;

    always @(posedge clk) begin
        if (!rst_n) begin
            m8Busy <= 1'b0; m8Done <= 1'b0; m8Diff <= '0; m8Borrow <= 1'b0; m8Left <= 0;
        end else begin
            m8Done <= 1'b0;
            if (m8Busy) begin
                m8Left <= m8Left - 1;
                if (m8Left == 1) begin
                    m8Busy   <= 1'b0;
                    m8Done   <= 1'b1;
                    m8Diff   <= m8PendDiff;
                    m8Borrow <= m8PendBorrow;
                end
            end else if (start8) begin
                m8Busy       <= 1'b1;
                m8Left       <= 8;
                m8PendDiff   <= a8 - b8;
                m8PendBorrow <= (a8 < b8);
            end
        end
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            m3Busy <= 1'b0; m3Done <= 1'b0; m3Diff <= '0; m3Borrow <= 1'b0; m3Left <= 0;
        end else begin
            m3Done <= 1'b0;
            if (m3Busy) begin
                m3Left <= m3Left - 1;
                if (m3Left == 1) begin
                    m3Busy   <= 1'b0;
                    m3Done   <= 1'b1;
                    m3Diff   <= m3PendDiff;
                    m3Borrow <= m3PendBorrow;
                end
            end else if (start3) begin
                m3Busy       <= 1'b1;
                m3Left       <= 3;
                m3PendDiff   <= a3 - b3;
                m3PendBorrow <= (a3 < b3);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (cmpEn) begin
            checkOutput("busy8",   32'(busy8),   32'(m8Busy));
            checkOutput("done8",   32'(done8),   32'(m8Done));
            checkOutput("diff8",   32'(diff8),   32'(m8Diff));
            checkOutput("borrow8", 32'(borrow8), 32'(m8Borrow));
            checkOutput("busy3",   32'(busy3),   32'(m3Busy));
            checkOutput("done3",   32'(done3),   32'(m3Done));
            checkOutput("diff3",   32'(diff3),   32'(m3Diff));
            checkOutput("borrow3", 32'(borrow3), 32'(m3Borrow));
        end
    end

    // Called at a falling edge; returns the cycle number of the accepting edge.
    task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, output int acc);
        a8 = av;
        b8 = bv;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        acc = cycle;
    endtask

    task automatic waitDone8(input string tag, input int acc);
        int n;
        n = 0;
        while (done8 !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (done8 !== 1'b1) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
        else checkOutput({tag, "_latency"}, 32'(cycle - acc), 32'd8);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] d;
        logic       br;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int acc;
        int prevDone;
        int n;
        logic [2:0] ea, eb, ed;
        logic [5:0] pair;
        logic ok;

        vecs[0] = '{8'h5A, 8'h3C, 8'h1E, 1'b0};
        vecs[1] = '{8'h00, 8'h01, 8'hFF, 1'b1};
        vecs[2] = '{8'h3C, 8'h5A, 8'hE2, 1'b1};
        vecs[3] = '{8'hA5, 8'hA5, 8'h00, 1'b0};
        vecs[4] = '{8'hFF, 8'h00, 8'hFF, 1'b0};

        rst_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0;
        start3 = 1'b0; a3 = '0; b3 = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        cmpEn = 1'b1;

        checkOutput("reset_busy",   32'(busy8),   32'd0);
        checkOutput("reset_done",   32'(done8),   32'd0);
        checkOutput("reset_diff",   32'(diff8),   32'd0);
        checkOutput("reset_borrow", 32'(borrow8), 32'd0);

        // Directed vectors, including underflow, equal operands and extremes.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, acc);
            checkOutput("accept_busy", 32'(busy8), 32'd1);
            waitDone8("vec", acc);
            checkOutput("vec_diff",   32'(diff8),   32'(vecs[i].d));
            checkOutput("vec_borrow", 32'(borrow8), 32'(vecs[i].br));
            if (i == 0) checkOutput("model8_diff", 32'(m8Diff), 32'h1E);
            @(negedge clk);
            checkOutput("done_drop", 32'(done8), 32'd0);
        end

        // A start pulse in the middle of a run must be ignored.
        applyStimulus(8'h10, 8'h01, acc);
        repeat (2) @(negedge clk);
        a8 = 8'h00; b8 = 8'hFF; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        waitDone8("busy_start", acc);
        checkOutput("busy_start_diff",   32'(diff8),   32'h0F);
        checkOutput("busy_start_borrow", 32'(borrow8), 32'd0);
        repeat (6) @(negedge clk);
        checkOutput("hold_diff",  32'(diff8),  32'h0F);
        checkOutput("model8_hold", 32'(m8Diff), 32'h0F);

        // Reset four edges into a run discards it completely.
        applyStimulus(8'h33, 8'h11, acc);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("midrst_busy",   32'(busy8),   32'd0);
        checkOutput("midrst_done",   32'(done8),   32'd0);
        checkOutput("midrst_diff",   32'(diff8),   32'd0);
        checkOutput("midrst_borrow", 32'(borrow8), 32'd0);
        repeat (12) @(negedge clk);
        applyStimulus(8'h07, 8'h03, acc);
        waitDone8("after_rst", acc);
        checkOutput("after_rst_diff", 32'(diff8), 32'h04);

        // Every 3-bit operand pair, each issued in the previous done cycle.
        a3 = 3'd0; b3 = 3'd0; start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        prevDone = 0;
        for (int k = 0; k < 64; k++) begin
            n = 0;
            while (done3 !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            ok = (done3 === 1'b1);
            checkOutput("exh_done_seen", 32'(ok), 32'd1);
            if (!ok) break;
            pair = 6'(k);
            ea = pair[5:3];
            eb = pair[2:0];
            ed = ea - eb;
            checkOutput("exh_result", 32'({borrow3, diff3}), 32'({(ea < eb), ed}));
            if (k > 0) checkOutput("exh_spacing", 32'(cycle - prevDone), 32'd4);
            prevDone = cycle;
            if (k < 63) begin
                pair = 6'(k + 1);
                a3 = pair[5:3];
                b3 = pair[2:0];
                start3 = 1'b1;
                @(negedge clk);
                start3 = 1'b0;
            end
        end
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
